// File: rtl/chn_in.sv
// Serial packet receiver: parses header/payload/parity bytes and forwards every accepted byte to a FIFO.
// Optional macro CHN_IN_PARITY_CHECK_EN enables parity checking; without it the parity byte is always accepted as good.
module chn_in #(
  parameter int data_size       = 8,
  parameter int pkt_length_bits = 5,
  parameter int pkt_addr_bits   = data_size - pkt_length_bits
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [data_size-1:0]     data_in,
  input  logic                     chn_en,
  input  logic                     clr_errors,
  output logic [data_size-1:0]     data_out,
  output logic                     pkt_to_fifo_en,
  output logic [pkt_addr_bits-1:0] pkt_addr,
  output logic                     busy,
  output logic                     pkt_done,
  output logic                     error
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY
  } state_t;

  state_t                     r_state;
  logic [pkt_length_bits-1:0] r_count;
  logic [data_size-1:0]       r_acc;
  logic [data_size-1:0]       r_data_out;
  logic                       r_fifo_en;
  logic [pkt_addr_bits-1:0]   r_addr;
  logic                       r_done;
  logic                       r_error;

  logic [pkt_length_bits-1:0] w_len;
  logic                       w_parity_ok;

  assign w_len = data_in[pkt_addr_bits +: pkt_length_bits];

`ifdef CHN_IN_PARITY_CHECK_EN
  assign w_parity_ok = (data_in == r_acc);
`else
  assign w_parity_ok = 1'b1;
`endif

  // NOTE: non-blocking assignments throughout; where r_error is written twice in one
  // cycle the later assignment wins, so a new error event overrides clr_errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_acc      <= '0;
      r_data_out <= '0;
      r_fifo_en  <= 1'b0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_fifo_en <= 1'b0;
      r_done    <= 1'b0;
      if (clr_errors) r_error <= 1'b0;

      case (r_state)
        IDLE: begin
          if (chn_en) begin
            if (w_len != '0) begin
              r_count    <= w_len;
              r_addr     <= data_in[pkt_addr_bits-1:0];
              r_acc      <= data_in;
              r_data_out <= data_in;
              r_fifo_en  <= 1'b1;
              r_state    <= PAYLOAD;
            end else begin
              r_error <= 1'b1;
            end
          end
        end

        PAYLOAD: begin
          if (chn_en) begin
            r_acc      <= r_acc ^ data_in;
            r_count    <= r_count - 1'b1;
            r_data_out <= data_in;
            r_fifo_en  <= 1'b1;
            if (r_count == pkt_length_bits'(1)) r_state <= PARITY;
          end else begin
            r_error <= 1'b1;
            r_state <= IDLE;
          end
        end

        PARITY: begin
          if (chn_en) begin
            r_data_out <= data_in;
            r_fifo_en  <= 1'b1;
            if (w_parity_ok) r_done  <= 1'b1;
            else             r_error <= 1'b1;
          end else begin
            r_error <= 1'b1;
          end
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign pkt_to_fifo_en = r_fifo_en;
  assign pkt_addr       = r_addr;
  assign busy           = (r_state != IDLE);
  assign pkt_done       = r_done;
  assign error          = r_error;

endmodule

// File: doc/chn_in.md
CHN_IN -- requirements
Module: chn_in

Interface
REQ-001 SHALL have parameter data_size, default 8, byte width of the channel.
REQ-002 SHALL have parameter pkt_length_bits, default 5, width of the header length field.
REQ-003 SHALL have parameter pkt_addr_bits, default data_size-pkt_length_bits (3), width of the header address field.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_in  input  data_size  serial packet byte.
REQ-007 SHALL have port chn_en  input  1  data_in valid this cycle.
REQ-008 SHALL have port clr_errors  input  1  clears the sticky error flag.
REQ-009 SHALL have port data_out  output  data_size  byte forwarded to the packet FIFO.
REQ-010 SHALL have port pkt_to_fifo_en  output  1  FIFO write strobe qualifying data_out.
REQ-011 SHALL have port pkt_addr  output  pkt_addr_bits  destination address of the current/last packet.
REQ-012 SHALL have port busy  output  1  packet in progress.
REQ-013 SHALL have port pkt_done  output  1  one-cycle pulse when a packet completes without error.
REQ-014 SHALL have port error  output  1  sticky protocol/parity error.

Function
REQ-015 Packet format SHALL be: header byte {length[data_size-1:pkt_addr_bits], addr[pkt_addr_bits-1:0]}, then length payload bytes, then one parity byte equal to the XOR of header and all payload bytes.
REQ-016 FSM states SHALL be IDLE, PAYLOAD, PARITY; busy SHALL be 1 exactly while state is not IDLE.
REQ-017 IDLE with chn_en=1 and length!=0 SHALL latch length and pkt_addr, seed the XOR accumulator with the header, and move to PAYLOAD.
REQ-018 IDLE with chn_en=1 and length==0 SHALL set error, not forward the byte, and stay in IDLE.
REQ-019 PAYLOAD SHALL accept one byte per cycle with chn_en=1, XOR it into the accumulator, and decrement the remaining count; it moves to PARITY after the last payload byte.
REQ-020 PARITY with chn_en=1 SHALL compare data_in to the accumulator, set error on mismatch, pulse pkt_done on match, and return to IDLE.
REQ-021 chn_en=0 in PAYLOAD or PARITY SHALL abort the packet: set error, no pkt_done, return to IDLE next cycle.
REQ-022 Every accepted byte (header, payload, parity) SHALL appear on data_out with pkt_to_fifo_en=1 exactly one cycle after it is sampled; pkt_to_fifo_en SHALL be 0 otherwise, and data_out SHALL hold its last value.
REQ-023 A new header MAY be accepted in the cycle immediately after the parity byte (back-to-back packets, no idle gap required).
REQ-024 error SHALL be sticky until clr_errors=1 is sampled; if clr_errors and a new error event occur in the same cycle, error SHALL remain 1.
REQ-025 An error SHALL NOT block reception; the FSM continues accepting packets while error=1.
REQ-026 pkt_done and pkt_to_fifo_en for the parity byte SHALL assert in the same cycle.

Reset
REQ-027 rstn=0 SHALL asynchronously force state=IDLE, data_out=0, pkt_to_fifo_en=0, pkt_addr=0, busy=0, pkt_done=0, error=0, and clear count and accumulator.
REQ-028 Reset asserted mid-packet SHALL discard the packet; after release, the first chn_en=1 byte SHALL be treated as a header.

Configuration
REQ-029 Macro CHN_IN_PARITY_CHECK_EN SHALL control parity checking.
REQ-030 With CHN_IN_PARITY_CHECK_EN defined, REQ-020 SHALL apply in full.
REQ-031 Without it, the parity byte SHALL still be consumed and forwarded, never set error, and pkt_done SHALL pulse unconditionally.

Verification
REQ-032 Send header 8'h1A (len 3, addr 2), payload 11/22/33, parity 8'h1A -> five FIFO writes 1A,11,22,33,1A each one cycle late; pkt_addr=2; pkt_done pulses once; error=0.
REQ-033 Same packet with parity 8'h00 -> five FIFO writes; error=1 (macro on); no pkt_done. Repeat with macro off -> error=0 and pkt_done pulses.
REQ-034 Send header 8'h01 (len 0) -> no FIFO write, busy stays 0, error=1; then clr_errors=1 -> error=0 next cycle.
REQ-035 Drop chn_en after the second payload byte of 8'h1A -> error=1, busy=0 next cycle, no pkt_done; the next 8'h1A packet completes normally.
REQ-036 Send two packets back-to-back, then assert rstn=0 mid-third packet -> first two complete; all outputs go 0 immediately; the first byte after reset is parsed as a header.
